// File: rtl/comp_pkg.sv
// Shared types and constants for the registered magnitude comparator.
package comp_pkg;

    // Encoded comparison outcome, decoded into one-hot flags at the output stage.
    typedef enum logic [1:0] {
        CMP_EQ = 2'd0,
        CMP_GT = 2'd1,
        CMP_LT = 2'd2
    } cmp_res_t;

    // Operand width used when the instantiating block does not override it.
    localparam int COMP_WIDTH_DEFAULT = 2;

endpackage

// File: rtl/comp_bit_cell.sv
// One stage of an MSB-first magnitude cascade. A decision already made by a
// more-significant stage passes straight through; otherwise this bit decides.
module comp_bit_cell (
    input  logic a_bit,
    input  logic b_bit,
    input  logic gt_hi,
    input  logic lt_hi,
    output logic gt,
    output logic lt
);

    // Forward an upstream decision, or resolve on this bit pair.
    always_comb begin
        gt = 1'b0;
        lt = 1'b0;
        if (gt_hi || lt_hi) begin
            gt = gt_hi;
            lt = lt_hi;
        end else begin
            gt = a_bit & ~b_bit;
            lt = ~a_bit & b_bit;
        end
    end

endmodule

// File: rtl/comparator_2bit.sv
// Registered magnitude comparator: one-hot gt/lt/eq flags one cycle after a
// valid operand pair. Flags hold while in_valid is low; out_valid marks a
// fresh result.
// Build option: define COMP_2BIT_SIGNED_EN to treat operands as two's
// complement (the sign bit stage compares with operand roles swapped).
module comparator_2bit
    import comp_pkg::*;
#(
    parameter int WIDTH = COMP_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_valid,
    output logic             gt,
    output logic             lt,
    output logic             eq,
    output logic             out_valid
);

    // Cascade nets: index WIDTH is the undecided seed above the MSB,
    // index 0 carries the final decision out of the LSB cell.
    logic [WIDTH:0]   gt_chain_s;
    logic [WIDTH:0]   lt_chain_s;
    logic [WIDTH-1:0] cell_a_s;
    logic [WIDTH-1:0] cell_b_s;
    cmp_res_t         res_s;

    logic gt_r;
    logic lt_r;
    logic eq_r;
    logic out_valid_r;

    assign gt_chain_s[WIDTH] = 1'b0;
    assign lt_chain_s[WIDTH] = 1'b0;

    // Select per-cell operands; a set sign bit means "smaller" in the signed build.
    always_comb begin
        cell_a_s = a;
        cell_b_s = b;
`ifdef COMP_2BIT_SIGNED_EN
        cell_a_s[WIDTH-1] = b[WIDTH-1];
        cell_b_s[WIDTH-1] = a[WIDTH-1];
`else
        cell_a_s[WIDTH-1] = a[WIDTH-1];
        cell_b_s[WIDTH-1] = b[WIDTH-1];
`endif
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        comp_bit_cell u_cell (
            .a_bit (cell_a_s[i]),
            .b_bit (cell_b_s[i]),
            .gt_hi (gt_chain_s[i+1]),
            .lt_hi (lt_chain_s[i+1]),
            .gt    (gt_chain_s[i]),
            .lt    (lt_chain_s[i])
        );
    end

    // Collapse the cascade outputs into a single encoded result.
    always_comb begin
        res_s = CMP_EQ;
        if (gt_chain_s[0]) begin
            res_s = CMP_GT;
        end else if (lt_chain_s[0]) begin
            res_s = CMP_LT;
        end else begin
            res_s = CMP_EQ;
        end
    end

    // Output registers: load flags on valid input, otherwise hold them; out_valid tracks in_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gt_r        <= 1'b0;
            lt_r        <= 1'b0;
            eq_r        <= 1'b0;
            out_valid_r <= 1'b0;
        end else if (in_valid) begin
            case (res_s)
                CMP_GT:  {gt_r, lt_r, eq_r} <= 3'b100;
                CMP_LT:  {gt_r, lt_r, eq_r} <= 3'b010;
                CMP_EQ:  {gt_r, lt_r, eq_r} <= 3'b001;
                default: {gt_r, lt_r, eq_r} <= 3'b000;
            endcase
            out_valid_r <= 1'b1;
        end else begin
            out_valid_r <= 1'b0;
        end
    end

    assign gt        = gt_r;
    assign lt        = lt_r;
    assign eq        = eq_r;
    assign out_valid = out_valid_r;

endmodule

// File: tb/tb_comparator_2bit.sv
// Scoreboard bench for comparator_2bit: the driver queues the expected flags
// for each valid pair, a negedge monitor pops and compares whenever out_valid
// is high. Reset, hold and mid-stream reset behaviour are checked directly.
module tb_comparator_2bit;

    logic       clk;
    logic       rst_n;
    logic [1:0] a;
    logic [1:0] b;
    logic       in_valid;
    logic       gt;
    logic       lt;
    logic       eq;
    logic       out_valid;

    int n_vec  = 0;
    int n_fail = 0;

    // Entry layout: {a, b, expected {gt,lt,eq}}
    logic [6:0] exp_q[$];

    comparator_2bit #(.WIDTH(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .in_valid  (in_valid),
        .gt        (gt),
        .lt        (lt),
        .eq        (eq),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference compare used for the exhaustive sweep.
    function automatic logic [2:0] model(input logic [1:0] x, input logic [1:0] y);
`ifdef COMP_2BIT_SIGNED_EN
        if ($signed(x) > $signed(y)) return 3'b100;
        else if ($signed(x) < $signed(y)) return 3'b010;
        else return 3'b001;
`else
        if (x > y) return 3'b100;
        else if (x < y) return 3'b010;
        else return 3'b001;
`endif
    endfunction

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got {gt,lt,eq,out_valid}=%b expected %b", name, act, expv);
        end
    endtask

    // Apply one pair just after a rising edge; queue its expected flags if it is a scored valid pair.
    task automatic drive(input logic [1:0] av, input logic [1:0] bv, input logic vld,
                         input logic push, input logic [2:0] expv);
        @(posedge clk);
        #1;
        a        = av;
        b        = bv;
        in_valid = vld;
        if (vld && push) exp_q.push_back({av, bv, expv});
    endtask

    // Monitor: every valid output cycle consumes one scoreboard entry.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_out: got {gt,lt,eq}=%b with no queued expectation", {gt, lt, eq});
            end else begin
                logic [6:0] e;
                e = exp_q.pop_front();
                if ({gt, lt, eq} !== e[2:0]) begin
                    n_fail++;
                    $display("FAIL cmp a=%0d b=%0d: got {gt,lt,eq}=%b expected %b",
                             e[6:5], e[4:3], {gt, lt, eq}, e[2:0]);
                end
            end
        end
    end

    // Hand-computed directed vectors.
    logic [1:0] dir_a [4];
    logic [1:0] dir_b [4];
    logic [2:0] dir_e [4];

    initial begin
`ifdef COMP_2BIT_SIGNED_EN
        dir_a = '{2'd2, 2'd3, 2'd1, 2'd2};
        dir_b = '{2'd1, 2'd0, 2'd3, 2'd2};
        dir_e = '{3'b010, 3'b010, 3'b100, 3'b001};
`else
        dir_a = '{2'd2, 2'd3, 2'd0, 2'd1};
        dir_b = '{2'd1, 2'd3, 2'd3, 2'd2};
        dir_e = '{3'b100, 3'b001, 3'b010, 3'b010};
`endif
        rst_n    = 1'b0;
        in_valid = 1'b0;
        a        = 2'($urandom_range(0, 3));
        b        = 2'($urandom_range(0, 3));

        // Reset held with arbitrary operands.
        #12;
        chk("reset_hold", {gt, lt, eq, out_valid}, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;
        drive(2'd1, 2'd2, 1'b0, 1'b0, 3'b000);
        drive(2'd3, 2'd0, 1'b0, 1'b0, 3'b000);
        @(posedge clk);
        #2;
        chk("reset_release_idle", {gt, lt, eq, out_valid}, 4'b0000);

        // Directed sequence, one pair per cycle.
        for (int i = 0; i < 4; i++) drive(dir_a[i], dir_b[i], 1'b1, 1'b1, dir_e[i]);

        // Hold: valid (3,0) then invalid (0,3).
        drive(2'd3, 2'd0, 1'b1, 1'b1, model(2'd3, 2'd0));
        drive(2'd0, 2'd3, 1'b0, 1'b0, 3'b000);
        @(posedge clk);
        #2;
        chk("hold", {gt, lt, eq, out_valid}, {model(2'd3, 2'd0), 1'b0});

        // Exhaustive back-to-back sweep.
        for (int i = 0; i < 16; i++) begin
            logic [3:0] v;
            v = 4'(i);
            drive(v[3:2], v[1:0], 1'b1, 1'b1, model(v[3:2], v[1:0]));
        end

        // Mid-stream reset: the (1,2) result is captured then discarded.
        drive(2'd1, 2'd2, 1'b1, 1'b0, 3'b000);
        @(posedge clk);
        #2;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("async_reset", {gt, lt, eq, out_valid}, 4'b0000);
        #1;
        rst_n = 1'b1;
        drive(2'd2, 2'd1, 1'b1, 1'b1, model(2'd2, 2'd1));
        drive(2'd2, 2'd2, 1'b1, 1'b1, 3'b001);
        drive(2'd0, 2'd0, 1'b0, 1'b0, 3'b000);
        repeat (3) @(posedge clk);
        #2;
        n_vec++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d results still outstanding, expected 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
